// File: rtl/enigma_top.sv
// enigma_top: byte-serial three-rotor Enigma-style cipher core for ASCII 'A'..'Z'.
//
// Ports:
//   clk                      rising-edge clock
//   reset_n                  synchronous reset, active HIGH (name kept for compatibility)
//   set                      load wirings / start positions / delays while high
//   en                       enable; valid is ignored when low
//   valid, dec, din[7:0]     one-cycle character strobe, decrypt select, ASCII character
//   *_offset[31:0]           rotor start positions (mod 26)
//   *_delay[31:0]            rotor stepping divisors (0 behaves as 1)
//   *_idx_in[207:0]          rotor wirings, byte i = ASCII image of letter i
//   reflector_idx_in[207:0]  reflector wiring (involution)
//   dout[7:0], done          ASCII result and one-cycle result strobe
//
// Build option: define LOWERCASE_IN_EN to fold 'a'..'z' to uppercase on input.
// Without it, lowercase characters pass through unchanged like any non-letter.
//
// state | meaning
// IDLE  | waiting for valid && en
// PREP  | decrypt undo-stepping of rotor positions
// F1    | first rotor, forward
// F2    | second rotor, forward
// F3    | third rotor, forward
// RF    | reflector
// B3    | third rotor, inverse
// B2    | second rotor, inverse
// B1    | first rotor, inverse; done, dout and encrypt stepping
module enigma_top (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         set,
  input  logic         en,
  input  logic         valid,
  input  logic         dec,
  input  logic [7:0]   din,
  input  logic [31:0]  first_offset,
  input  logic [31:0]  second_offset,
  input  logic [31:0]  third_offset,
  input  logic [31:0]  first_delay,
  input  logic [31:0]  second_delay,
  input  logic [31:0]  third_delay,
  input  logic [207:0] first_idx_in,
  input  logic [207:0] second_idx_in,
  input  logic [207:0] third_idx_in,
  input  logic [207:0] reflector_idx_in,
  output logic [7:0]   dout,
  output logic         done
);

  typedef enum logic [3:0] {
    S_IDLE, S_PREP, S_F1, S_F2, S_F3, S_RF, S_B3, S_B2, S_B1
  } state_t;

  typedef logic [25:0][4:0] tbl_t;

  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  // Result is below 26, so wrapping through 5 bits is exact.
  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    if (a >= b) return a - b;
    return a + 5'd26 - b;
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] a);
    return (a == 5'd25) ? 5'd0 : a + 5'd1;
  endfunction

  function automatic logic [4:0] dec26(input logic [4:0] a);
    return (a == 5'd0) ? 5'd25 : a - 5'd1;
  endfunction

  function automatic logic [4:0] mod26(input logic [31:0] v);
    return 5'(v % 32'd26);
  endfunction

  function automatic tbl_t to_tbl(input logic [207:0] v);
    tbl_t t;
    for (int i = 0; i < 26; i++) t[i] = 5'(v[8*i +: 8] - 8'd65);
    return t;
  endfunction

  // Search form avoids writing through an out-of-range index on bad wirings.
  function automatic tbl_t inv_tbl(input tbl_t t);
    tbl_t r;
    r = '0;
    for (int j = 0; j < 26; j++)
      for (int i = 0; i < 26; i++)
        if (t[i] == 5'(j)) r[j] = 5'(i);
    return r;
  endfunction

  function automatic logic [4:0] rotor(input tbl_t t, input logic [4:0] x, input logic [4:0] p);
    return sub26(t[add26(x, p)], p);
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  dout_q, dout_d;
  logic        done_q, done_d;
  logic [7:0]  din_q, din_d;
  logic        letter_q, letter_d;
  logic        dec_q, dec_d;
  logic [4:0]  x_q, x_d;
  logic [4:0]  p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [31:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic [31:0] dly1_q, dly1_d, dly2_q, dly2_d, dly3_q, dly3_d;
  tbl_t        w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
  tbl_t        wi1_q, wi1_d, wi2_q, wi2_d, wi3_q, wi3_d;
  tbl_t        ref_q, ref_d;

  logic        is_up, is_low, letter_in;
  logic [4:0]  x_in, y_b1;
  logic [31:0] d1, d2, d3;

  always_comb begin
    is_up = (din >= 8'd65) && (din <= 8'd90);
`ifdef LOWERCASE_IN_EN
    is_low = (din >= 8'd97) && (din <= 8'd122);
`else
    is_low = 1'b0;
`endif
    letter_in = is_up || is_low;
    x_in      = is_low ? 5'(din - 8'd97) : 5'(din - 8'd65);

    d1 = (dly1_q == 32'd0) ? 32'd1 : dly1_q;
    d2 = (dly2_q == 32'd0) ? 32'd1 : dly2_q;
    d3 = (dly3_q == 32'd0) ? 32'd1 : dly3_q;
    y_b1 = rotor(wi1_q, x_q, p1_q);

    state_d  = state_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    din_d    = din_q;
    letter_d = letter_q;
    dec_d    = dec_q;
    x_d      = x_q;
    p1_d = p1_q;  p2_d = p2_q;  p3_d = p3_q;
    c1_d = c1_q;  c2_d = c2_q;  c3_d = c3_q;
    dly1_d = dly1_q;  dly2_d = dly2_q;  dly3_d = dly3_q;
    w1_d = w1_q;  w2_d = w2_q;  w3_d = w3_q;
    wi1_d = wi1_q;  wi2_d = wi2_q;  wi3_d = wi3_q;
    ref_d = ref_q;

    if (set) begin
      // Loading aborts whatever character is in flight.
      state_d = S_IDLE;
      p1_d = mod26(first_offset);
      p2_d = mod26(second_offset);
      p3_d = mod26(third_offset);
      c1_d = '0;  c2_d = '0;  c3_d = '0;
      dly1_d = first_delay;  dly2_d = second_delay;  dly3_d = third_delay;
      w1_d  = to_tbl(first_idx_in);
      w2_d  = to_tbl(second_idx_in);
      w3_d  = to_tbl(third_idx_in);
      ref_d = to_tbl(reflector_idx_in);
      wi1_d = inv_tbl(w1_d);
      wi2_d = inv_tbl(w2_d);
      wi3_d = inv_tbl(w3_d);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid && en) begin
            din_d    = din;
            dec_d    = dec;
            letter_d = letter_in;
            x_d      = x_in;
            state_d  = S_PREP;
          end
        end
        S_PREP: begin
          // Undo of the encrypt step: rewinds the counters exactly one character.
          if (letter_q && dec_q) begin
            if (c1_q == 32'd0) begin
              c1_d = d1 - 32'd1;
              p1_d = dec26(p1_q);
              if (c2_q == 32'd0) begin
                c2_d = d2 - 32'd1;
                p2_d = dec26(p2_q);
                if (c3_q == 32'd0) begin
                  c3_d = d3 - 32'd1;
                  p3_d = dec26(p3_q);
                end else begin
                  c3_d = c3_q - 32'd1;
                end
              end else begin
                c2_d = c2_q - 32'd1;
              end
            end else begin
              c1_d = c1_q - 32'd1;
            end
          end
          state_d = S_F1;
        end
        S_F1: begin x_d = rotor(w1_q, x_q, p1_q);  state_d = S_F2; end
        S_F2: begin x_d = rotor(w2_q, x_q, p2_q);  state_d = S_F3; end
        S_F3: begin x_d = rotor(w3_q, x_q, p3_q);  state_d = S_RF; end
        S_RF: begin x_d = ref_q[x_q];              state_d = S_B3; end
        S_B3: begin x_d = rotor(wi3_q, x_q, p3_q); state_d = S_B2; end
        S_B2: begin x_d = rotor(wi2_q, x_q, p2_q); state_d = S_B1; end
        S_B1: begin
          done_d  = 1'b1;
          dout_d  = letter_q ? (8'd65 + {3'b000, y_b1}) : din_q;
          state_d = S_IDLE;
          if (letter_q && !dec_q) begin
            c1_d = c1_q + 32'd1;
            if (c1_d == d1) begin
              c1_d = '0;
              p1_d = inc26(p1_q);
              c2_d = c2_q + 32'd1;
              if (c2_d == d2) begin
                c2_d = '0;
                p2_d = inc26(p2_q);
                c3_d = c3_q + 32'd1;
                if (c3_d == d3) begin
                  c3_d = '0;
                  p3_d = inc26(p3_q);
                end
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q  <= S_IDLE;
      dout_q   <= '0;
      done_q   <= 1'b0;
      din_q    <= '0;
      letter_q <= 1'b0;
      dec_q    <= 1'b0;
      x_q      <= '0;
      p1_q <= '0;  p2_q <= '0;  p3_q <= '0;
      c1_q <= '0;  c2_q <= '0;  c3_q <= '0;
      dly1_q <= '0;  dly2_q <= '0;  dly3_q <= '0;
      w1_q <= '0;  w2_q <= '0;  w3_q <= '0;
      wi1_q <= '0;  wi2_q <= '0;  wi3_q <= '0;
      ref_q <= '0;
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      din_q    <= din_d;
      letter_q <= letter_d;
      dec_q    <= dec_d;
      x_q      <= x_d;
      p1_q <= p1_d;  p2_q <= p2_d;  p3_q <= p3_d;
      c1_q <= c1_d;  c2_q <= c2_d;  c3_q <= c3_d;
      dly1_q <= dly1_d;  dly2_q <= dly2_d;  dly3_q <= dly3_d;
      w1_q <= w1_d;  w2_q <= w2_d;  w3_q <= w3_d;
      wi1_q <= wi1_d;  wi2_q <= wi2_d;  wi3_q <= wi3_d;
      ref_q <= ref_d;
    end
  end

  assign dout = dout_q;
  assign done = done_q;

endmodule

// File: tb/tb_enigma_top.sv
// tb_enigma_top: scoreboard bench for enigma_top. Expected characters and the
// cycle at which done must appear are queued when a character is driven and
// popped by a monitor on each done pulse. Honours LOWERCASE_IN_EN when defined.
module tb_enigma_top;

  logic         clk = 1'b0;
  logic         reset_n, set, en, valid, dec;
  logic [7:0]   din;
  logic [31:0]  first_offset, second_offset, third_offset;
  logic [31:0]  first_delay, second_delay, third_delay;
  logic [207:0] first_idx_in, second_idx_in, third_idx_in, reflector_idx_in;
  logic [7:0]   dout;
  logic         done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int cnt0;
  byte unsigned exp_q[$];
  int due_q[$];
  byte unsigned mon_exp;
  int mon_due;

  enigma_top dut (
    .clk(clk), .reset_n(reset_n), .set(set), .en(en), .valid(valid), .dec(dec), .din(din),
    .first_offset(first_offset), .second_offset(second_offset), .third_offset(third_offset),
    .first_delay(first_delay), .second_delay(second_delay), .third_delay(third_delay),
    .first_idx_in(first_idx_in), .second_idx_in(second_idx_in), .third_idx_in(third_idx_in),
    .reflector_idx_in(reflector_idx_in), .dout(dout), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("done_unexpected", {31'b0, done}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_due = due_q.pop_front();
        chk("dout", {24'b0, dout}, {24'b0, mon_exp});
        chk("latency", cyc, mon_due);
      end
    end
  end

  function automatic logic [207:0] mk_tbl(input bit rev);
    logic [207:0] v;
    for (int i = 0; i < 26; i++) v[8*i +: 8] = rev ? 8'(90 - i) : 8'(65 + i);
    return v;
  endfunction

  task automatic cfg(input bit rev, input int o1, input int o2, input int o3,
                     input int d1, input int d2, input int d3);
    @(negedge clk);
    first_idx_in = mk_tbl(rev);  second_idx_in = mk_tbl(rev);
    third_idx_in = mk_tbl(rev);  reflector_idx_in = mk_tbl(rev);
    first_offset = o1;  second_offset = o2;  third_offset = o3;
    first_delay = d1;   second_delay = d2;   third_delay = d3;
    set = 1'b1;
    @(negedge clk);
    set = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      due_q.delete();
    end
  endtask

  task automatic send(input byte unsigned c, input bit d, input byte unsigned e);
    @(negedge clk);
    din = c;  dec = d;  valid = 1'b1;
    exp_q.push_back(e);
    due_q.push_back(cyc + 9);
    @(negedge clk);
    valid = 1'b0;
    drain();
  endtask

  task automatic send_str(input string s, input string e, input bit d);
    for (int i = 0; i < s.len(); i++) send(s[i], d, e[i]);
  endtask

  // Strobe a character that is expected to be dropped.
  task automatic pulse_valid(input byte unsigned c);
    @(negedge clk);
    din = c;  dec = 1'b0;  valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;  set = 1'b0;  en = 1'b1;  valid = 1'b0;  dec = 1'b0;  din = '0;
    first_offset = '0;  second_offset = '0;  third_offset = '0;
    first_delay = '0;   second_delay = '0;   third_delay = '0;
    first_idx_in = '0;  second_idx_in = '0;  third_idx_in = '0;  reflector_idx_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", {24'b0, dout}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    reset_n = 1'b0;

    // identity wiring passes letters through regardless of offsets
    cfg(1'b0, 2, 3, 1, 4, 3, 3);
    send_str("SORLAB", "SORLAB", 1'b0);

    // reversal wiring, every rotor stepping each character, then undo
    cfg(1'b1, 0, 0, 0, 1, 1, 1);
    send_str("AAA", "ZVR", 1'b0);
    send_str("RVZ", "AAA", 1'b1);

    // slower first rotor and a start offset
    cfg(1'b1, 1, 0, 0, 2, 1, 1);
    send_str("BBB", "UUQ", 1'b0);
    send_str("QUU", "BBB", 1'b1);

    // non-letters and disabled strobes do not step the rotors
    cfg(1'b1, 0, 0, 0, 1, 1, 1);
    send("5", 1'b0, "5");
    send("5", 1'b1, "5");
    en = 1'b0;
    cnt0 = done_cnt;
    pulse_valid("A");
    repeat (12) @(negedge clk);
    chk("en_low_nodone", done_cnt, cnt0);
    en = 1'b1;
    send("A", 1'b0, "Z");
    send("A", 1'b0, "V");

    // set during a character aborts it and reloads positions
    pulse_valid("A");
    repeat (3) @(negedge clk);
    cnt0 = done_cnt;
    cfg(1'b1, 0, 0, 0, 1, 1, 1);
    repeat (12) @(negedge clk);
    chk("set_abort_nodone", done_cnt, cnt0);
    send("A", 1'b0, "Z");

    // zero delays behave like one
    cfg(1'b1, 0, 0, 0, 0, 0, 0);
    send_str("AA", "ZV", 1'b0);

    // reset during a character drops it and clears dout
    pulse_valid("B");
    repeat (3) @(negedge clk);
    cnt0 = done_cnt;
    reset_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_mid_nodone", done_cnt, cnt0);
    chk("rst_mid_dout", {24'b0, dout}, 32'd0);

    // lowercase handling
    cfg(1'b1, 0, 0, 0, 1, 1, 1);
`ifdef LOWERCASE_IN_EN
    send_str("aaa", "ZVR", 1'b0);
`else
    send("a", 1'b0, "a");
    send("A", 1'b0, "Z");
`endif

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enigma_top.md
Name: enigma_top

Overview:
- Byte-serial, three-rotor Enigma-style cipher core for ASCII 'A'..'Z'.
- Rotor wirings, reflector wiring, start positions and stepping rates are loaded through a `set` strobe.
- Characters are then encrypted, or decrypted with rotor back-stepping, one at a time using a valid/done handshake.
- The block is the top level of the cipher; there are no submodule requirements.

Parameters:
- LAT, 8, clock edges from valid acceptance to done; fixed and not user-tunable, stated for verification.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-high reset. The port keeps the codebase name; it is active-high despite the suffix.
- set  in  1  load configuration while high.
- en  in  1  enable; valid is ignored when low.
- valid  in  1  one-cycle character strobe.
- dec  in  1  sampled with valid: 1 = decrypt, 0 = encrypt.
- din  in  8  ASCII input character.
- first_offset/second_offset/third_offset  in  32 each  start positions, used mod 26.
- first_delay/second_delay/third_delay  in  32 each  stepping divisors; 0 is treated as 1.
- first_idx_in/second_idx_in/third_idx_in  in  208 each  rotor wiring. Byte i (bits 8i+7:8i) is the ASCII image of letter i.
- reflector_idx_in  in  208  reflector wiring, same format; must be an involution.
- dout  out  8  ASCII result.
- done  out  1  one-cycle result strobe.

Behaviour:
- Reset: dout=0, done=0, FSM to IDLE; positions, step counters, wirings and delays cleared.
- Set: each edge with set=1 (and reset low) does the following:
  - latches p_k = offset_k mod 26, the delays, W_k = idx_k - 65 and Ref = reflector - 65;
  - builds the inverse tables Winv_k;
  - clears the step counters and aborts any character in progress (done stays 0).
  - set has priority over valid.
- Acceptance: valid=1, en=1, set=0 in IDLE. valid in any other state is ignored.
- Letter index: x = din - 65.
- Rotor forward: y = (W_k[(x+p_k)%26] - p_k) mod 26.
- Rotor backward: y = (Winv_k[(x+p_k)%26] - p_k) mod 26.
- Path: first, second, third, reflector, third⁻¹, second⁻¹, first⁻¹. One stage per cycle; states IDLE, PREP, F1, F2, F3, RF, B3, B2, B1.
- Output: dout = y + 65. done=1 exactly LAT edges after the accepting edge, for one cycle. dout holds until the next done.
- Encrypt stepping is applied at the done edge, using the positions in effect during the path:
  - c1 increments; if c1 reaches delay1 then c1=0, p1+=1, and c2 increments.
  - The same rule cascades to rotor 3. Position wrap is 25→0.
- Decrypt stepping is an undo applied in PREP, before the path:
  - If c1 is 0: c1 = delay1-1, p1-=1 (0→25), and the undo cascades to c2/p2, then c3/p3.
  - Otherwise: c1-=1 and nothing cascades.
  - Consequence: the ciphertext of an encrypt sequence, fed in reverse order with dec=1, yields the plaintext in reverse order.
- Non-letter din (outside 65..90): dout=din, done at the same latency, no stepping and no undo.
- Reset mid-operation: the character is dropped and no done is produced.

Optional Feature:
- Macro: LOWERCASE_IN_EN.
- Defined: din 'a'..'z' (97..122) is folded to uppercase before processing and is stepped like a letter. dout is always uppercase.
- Undefined: lowercase characters are non-letters and pass through unchanged with no stepping.

Test Plan:
- Pass-through: all tables identity (byte i = 65+i), offsets 2/3/1, delays 4/3/3; encrypt "SORLAB" → "SORLAB". Each done arrives exactly 8 edges after its valid.
- Reversal tables: all four tables byte i = 90-i, offsets 0/0/0, delays 1/1/1; encrypt "AAA" → "ZVR".
- Decrypt: continuing the previous case, dec=1 with inputs "R","V","Z" → "A","A","A".
- Delay and offset: reversal tables, offsets 1/0/0, delays 2/1/1; encrypt "BBB" → "UUQ". Then decrypt "Q","U","U" → "BBB".
- Edge cases:
  - din='5' → dout='5' with no step: the next 'A' in the reversal 0/0/0 case still gives 'Z'.
  - valid with en=0 → no done.
  - set pulsed mid-character → no done, and positions reload.
- Reset and options:
  - reset_n=1 during a character → done never rises, dout=0.
  - With LOWERCASE_IN_EN defined, "aaa" in the reversal 0/0/0 case → "ZVR".
